// File: rtl/pair_checker.sv
// pair_checker - pick/compare engine for the pairs memory game
//
// Watches select pulses at the current cursor and latches two picks from the
// board labels. It compares the two labels, then reports a match (par) or a
// mismatch (mismatch + hide window). It keeps the matched-cell mask and the
// pair count, and raises finish once every pair has been found.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_select         one-cycle pick pulse (already synchronised/edge-detected)
//   i_cursor         index of the cell under the cursor
//   i_cells          cell labels, cell i at [i*LBL_W +: LBL_W], 0 = blank
//   o_first_valid    first pick is held
//   o_first_idx      index of the first pick
//   o_par            one-cycle pulse: pair matched
//   o_mismatch       one-cycle pulse: pair not matched
//   o_hide           level: both picks shown, turned face-down when it falls
//   o_busy           comparing or showing a mismatch; selects are dropped
//   o_matched_mask   bit i set = cell i permanently matched
//   o_pairs          matched pair count (saturates at N_PAIRS)
//   o_finish         all pairs found, held until reset
module pair_checker #(
  parameter int N_CELLS     = 16,
  parameter int N_PAIRS     = 8,
  parameter int LBL_W       = 4,
  parameter int HIDE_CYCLES = 4,
  localparam int PAIRS_W    = $clog2(N_PAIRS + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_select,
  input  logic [3:0]                 i_cursor,
  input  logic [N_CELLS*LBL_W-1:0]   i_cells,
  output logic                       o_first_valid,
  output logic [3:0]                 o_first_idx,
  output logic                       o_par,
  output logic                       o_mismatch,
  output logic                       o_hide,
  output logic                       o_busy,
  output logic [N_CELLS-1:0]         o_matched_mask,
  output logic [PAIRS_W-1:0]         o_pairs,
  output logic                       o_finish
);

  localparam int HC_W = (HIDE_CYCLES > 1) ? $clog2(HIDE_CYCLES) : 1;
  localparam logic [PAIRS_W-1:0] PAIRS_MAX = PAIRS_W'(N_PAIRS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ONE,
    S_CMP,
    S_SHOW,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_first_valid;
  logic [3:0]          r_first_idx;
  logic [LBL_W-1:0]    r_first_lbl;
  logic [3:0]          r_second_idx;
  logic [LBL_W-1:0]    r_second_lbl;
  logic                r_par;
  logic                r_mismatch;
  logic                r_hide;
  logic                r_busy;
  logic [HC_W-1:0]     r_hide_cnt;
  logic [N_CELLS-1:0]  r_mask;
  logic [PAIRS_W-1:0]  r_pairs;
  logic                r_finish;

  logic                w_in_range;
  logic                w_cur_matched;
  logic                w_pick_ok;
  logic [LBL_W-1:0]    w_cur_lbl;
  logic                w_labels_match;
  logic [PAIRS_W-1:0]  w_pairs_next;

  // A cursor past the last cell (smaller boards) is never a legal pick.
  assign w_in_range = (32'(i_cursor) < N_CELLS);

  always_comb begin
    w_cur_matched = 1'b0;
    if (w_in_range) begin
      w_cur_matched = r_mask[i_cursor];
    end
  end

  assign w_pick_ok      = i_select & w_in_range & ~w_cur_matched;
  assign w_cur_lbl      = i_cells[32'(i_cursor)*LBL_W +: LBL_W];
  // Blank cells carry label 0 and must never pair with each other.
  assign w_labels_match = (r_first_lbl == r_second_lbl) && (r_first_lbl != '0);
  assign w_pairs_next   = (r_pairs == PAIRS_MAX) ? r_pairs : r_pairs + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_first_valid <= 1'b0;
      r_first_idx   <= '0;
      r_first_lbl   <= '0;
      r_second_idx  <= '0;
      r_second_lbl  <= '0;
      r_par         <= 1'b0;
      r_mismatch    <= 1'b0;
      r_hide        <= 1'b0;
      r_busy        <= 1'b0;
      r_hide_cnt    <= '0;
      r_mask        <= '0;
      r_pairs       <= '0;
      r_finish      <= 1'b0;
    end else begin
      r_par      <= 1'b0;
      r_mismatch <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_ok) begin
            r_first_idx   <= i_cursor;
            r_first_lbl   <= w_cur_lbl;
            r_first_valid <= 1'b1;
            r_state       <= S_ONE;
          end
        end
        S_ONE: begin
          // Re-selecting the held cell is not a second pick.
          if (w_pick_ok && (i_cursor != r_first_idx)) begin
            r_second_idx <= i_cursor;
            r_second_lbl <= w_cur_lbl;
            r_busy       <= 1'b1;
            r_state      <= S_CMP;
          end
        end
        S_CMP: begin
          r_first_valid <= 1'b0;
          if (w_labels_match) begin
            r_mask[r_first_idx]  <= 1'b1;
            r_mask[r_second_idx] <= 1'b1;
            r_pairs              <= w_pairs_next;
            r_par                <= 1'b1;
            r_busy               <= 1'b0;
            if (w_pairs_next == PAIRS_MAX) begin
              r_finish <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_mismatch <= 1'b1;
            r_hide     <= 1'b1;
            // hide rises on this edge, so HIDE_CYCLES-1 more edges keep it up.
            r_hide_cnt <= HC_W'(HIDE_CYCLES - 1);
            r_state    <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (r_hide_cnt == '0) begin
            r_hide  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_hide_cnt <= r_hide_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_finish <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_first_valid  = r_first_valid;
  assign o_first_idx    = r_first_idx;
  assign o_par          = r_par;
  assign o_mismatch     = r_mismatch;
  assign o_hide         = r_hide;
  assign o_busy         = r_busy;
  assign o_matched_mask = r_mask;
  assign o_pairs        = r_pairs;
  assign o_finish       = r_finish;

endmodule

// File: tb/tb_pair_checker.sv
// tb/tb_pair_checker.sv - self-checking bench for pair_checker
module tb_pair_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        select = 1'b0;
  logic [3:0]  cursor = 4'h0;
  logic [63:0] cells_v = 64'h0;

  logic        first_valid, par, mismatch, hide, busy, finish;
  logic [3:0]  first_idx, pairs;
  logic [15:0] mask;

  logic        u_fv, u_par, u_mis, u_hide, u_busy, u_fin;
  logic [3:0]  u_idx;
  logic [2:0]  u_pairs;
  logic [11:0] u_mask;

  pair_checker dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_select(select), .i_cursor(cursor), .i_cells(cells_v),
    .o_first_valid(first_valid), .o_first_idx(first_idx), .o_par(par), .o_mismatch(mismatch),
    .o_hide(hide), .o_busy(busy), .o_matched_mask(mask), .o_pairs(pairs), .o_finish(finish)
  );

  pair_checker #(.N_CELLS(12), .N_PAIRS(6)) dut12 (
    .i_clk(clk), .i_rst_n(rst_n), .i_select(select), .i_cursor(cursor), .i_cells(cells_v[47:0]),
    .o_first_valid(u_fv), .o_first_idx(u_idx), .o_par(u_par), .o_mismatch(u_mis),
    .o_hide(u_hide), .o_busy(u_busy), .o_matched_mask(u_mask), .o_pairs(u_pairs), .o_finish(u_fin)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: game-level view of the board.
  int          m_first;
  logic [3:0]  m_first_lbl;
  logic [15:0] m_mask;
  int          m_pairs;
  bit          m_done;
  bit          noise_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_first = -1;
    m_first_lbl = 4'h0;
    m_mask = 16'h0;
    m_pairs = 0;
    m_done = 1'b0;
  endtask

  function automatic logic [3:0] lbl_of(input logic [3:0] c);
    return cells_v[int'(c)*4 +: 4];
  endfunction

  // Unmatched cell carrying the same label as the held first pick, or -1.
  function automatic int partner();
    for (int i = 0; i < 16; i++) begin
      if (i != m_first && !m_mask[i] && lbl_of(4'(i)) == m_first_lbl && m_first_lbl != 4'h0)
        return i;
    end
    return -1;
  endfunction

  task automatic pick(input logic [3:0] cur);
    bit         valid;
    logic [3:0] lbl;
    int         cnt;
    int         iters;
    valid = !m_done && !m_mask[cur];
    lbl = lbl_of(cur);
    select = 1'b1;
    cursor = cur;
    @(posedge clk);
    #1 select = 1'b0;
    if (!valid || (m_first >= 0 && int'(cur) == m_first)) begin
      check("ign_first_valid", first_valid, m_first >= 0);
      if (m_first >= 0) check("ign_first_idx", first_idx, m_first);
      check("ign_par", par, 0);
      check("ign_mismatch", mismatch, 0);
      check("ign_busy", busy, 0);
      return;
    end
    if (m_first < 0) begin
      m_first = int'(cur);
      m_first_lbl = lbl;
      check("first_valid", first_valid, 1);
      check("first_idx", first_idx, cur);
      check("first_busy", busy, 0);
      return;
    end
    check("cmp_busy", busy, 1);
    check("cmp_par_early", par | mismatch, 0);
    check("cmp_first_valid", first_valid, 1);
    @(posedge clk);
    #1;
    if (lbl == m_first_lbl && lbl != 4'h0) begin
      m_mask[cur] = 1'b1;
      m_mask[m_first] = 1'b1;
      if (m_pairs < 8) m_pairs++;
      if (m_pairs == 8) m_done = 1'b1;
      check("match_par", par, 1);
      check("match_mismatch", mismatch, 0);
      check("match_first_valid", first_valid, 0);
      check("match_mask", mask, m_mask);
      check("match_pairs", pairs, m_pairs);
      check("match_finish", finish, m_done);
      check("match_busy", busy, 0);
      @(posedge clk);
      #1;
      check("par_one_cycle", par, 0);
    end else begin
      check("mis_pulse", mismatch, 1);
      check("mis_par", par, 0);
      check("mis_hide", hide, 1);
      check("mis_busy", busy, 1);
      check("mis_first_valid", first_valid, 0);
      check("mis_mask", mask, m_mask);
      cnt = 1;
      iters = 0;
      while (hide === 1'b1 && iters < 20) begin
        if (noise_en) begin
          select = 1'($urandom_range(0, 1));
          cursor = 4'($urandom_range(0, 15));
        end
        @(posedge clk);
        #1 select = 1'b0;
        iters++;
        if (iters == 1) check("mis_one_cycle", mismatch, 0);
        if (hide === 1'b1) cnt++;
      end
      check("hide_cycles", cnt, 4);
      check("show_exit_busy", busy, 0);
      check("show_exit_first_valid", first_valid, 0);
      check("show_mask", mask, m_mask);
      check("show_pairs", pairs, m_pairs);
    end
    m_first = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int         lbls[16];
    int         j, t;
    model_reset();

    // Reset with select toggling.
    for (int i = 0; i < 3; i++) begin
      select = ~select;
      cursor = 4'(i);
      @(posedge clk);
      #1;
    end
    select = 1'b0;
    check("rst_outputs", {first_valid, first_idx, par, mismatch, hide, busy, pairs, finish}, 0);
    check("rst_mask", mask, 0);
    check("rst_u12_fv", u_fv, 0);
    rst_n = 1'b1;

    cells_v = 64'h0;
    cells_v[0*4 +: 4] = 4'h3;
    cells_v[5*4 +: 4] = 4'h3;
    cells_v[1*4 +: 4] = 4'h2;
    cells_v[2*4 +: 4] = 4'h7;
    cells_v[3*4 +: 4] = 4'h9;

    // Out-of-range cursor on the 12-cell board; two blanks on the main board.
    noise_en = 1'b0;
    pick(4'hF);
    check("u12_oor_ignored", u_fv, 0);
    pick(4'hB);
    check("u12_pick_fv", u_fv, 1);
    check("u12_pick_idx", u_idx, 4'hB);
    noise_en = 1'b1;

    // Match 0/5.
    pick(4'h0);
    pick(4'h5);
    check("dir_match_mask", mask, 16'h0021);
    check("dir_match_pairs", pairs, 1);

    // Mismatch 1/2.
    pick(4'h1);
    pick(4'h2);
    check("dir_mis_mask", mask, 16'h0021);

    // Ignored picks: same cell twice, matched cells, then blank partner.
    pick(4'h3);
    pick(4'h3);
    pick(4'h0);
    pick(4'h5);
    check("dir_ign_idx", first_idx, 4'h3);
    pick(4'h4);
    pick(4'h6);
    pick(4'h7);

    // Reset in the 2nd hide cycle.
    pick(4'h1);
    select = 1'b1;
    cursor = 4'h2;
    @(posedge clk);
    #1 select = 1'b0;
    @(posedge clk);
    #1;
    check("rs_hide_up", hide, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rs_hide", hide, 0);
    check("rs_first_valid", first_valid, 0);
    check("rs_mask", mask, 0);
    check("rs_pairs", pairs, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    pick(4'h3);
    check("rs_new_pick", first_valid, 1);

    // Full randomized game from reset.
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) lbls[i] = i / 2 + 1;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = lbls[i];
      lbls[i] = lbls[j];
      lbls[j] = t;
    end
    for (int i = 0; i < 16; i++) cells_v[i*4 +: 4] = 4'(lbls[i]);
    for (int it = 0; it < 3000 && !m_done; it++) begin
      logic [3:0] c;
      if (m_first >= 0 && $urandom_range(0, 2) == 0 && partner() >= 0) c = 4'(partner());
      else c = 4'($urandom_range(0, 15));
      pick(c);
    end
    check("game_finish", finish, 1);
    check("game_pairs", pairs, 8);
    check("game_mask", mask, 16'hFFFF);
    for (int i = 0; i < 4; i++) pick(4'($urandom_range(0, 15)));
    check("done_finish_held", finish, 1);
    check("done_pairs_held", pairs, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
